// File: rtl/pcie_hcmd_nlb_rd_arb_if.sv
// rtl/pcie_hcmd_nlb_rd_arb_if.sv - one consumer's NLB lookup request/response channel
interface pcie_hcmd_nlb_rd_arb_if #(
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_DATA_WIDTH = 19
);
    logic                    req;
    logic [P_ADDR_WIDTH-1:0] addr;
    logic                    rdy_n;
    logic                    data_valid;
    logic [P_DATA_WIDTH-1:0] data;

    // Consumer side: issues slot-tag lookups, receives NLB values
    modport master (
        output req,
        output addr,
        input  rdy_n,
        input  data_valid,
        input  data
    );

    // Arbiter side: accepts lookups, returns NLB values
    modport slave (
        input  req,
        input  addr,
        output rdy_n,
        output data_valid,
        output data
    );
endinterface

// File: rtl/pcie_hcmd_nlb_rd_arb.sv
// rtl/pcie_hcmd_nlb_rd_arb.sv - round-robin read front end for the per-slot-tag NLB table
module pcie_hcmd_nlb_rd_arb #(
    parameter int P_SLOT_TAG_WIDTH = 10,
    parameter int P_DATA_WIDTH     = 19,
    parameter int P_ADDR_WIDTH     = P_SLOT_TAG_WIDTH,
    parameter int P_RD_LATENCY     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    pcie_hcmd_nlb_rd_arb_if.slave   rd0,
    pcie_hcmd_nlb_rd_arb_if.slave   rd1,
    output logic                    tbl_rd_en,
    output logic [P_ADDR_WIDTH-1:0] tbl_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] tbl_rd_data
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ADDR = 4'b0010,
        S_WAIT = 4'b0100,
        S_DATA = 4'b1000
    } state_t;

    state_t                  state;
    logic [1:0]              pend;
    logic                    last_grant;
    logic                    grant;
    logic                    next_grant;
    logic                    acc0;
    logic                    acc1;
    logic [P_ADDR_WIDTH-1:0] addr0_q;
    logic [P_ADDR_WIDTH-1:0] addr1_q;
    logic                    dv0_q;
    logic                    dv1_q;
    logic [P_DATA_WIDTH-1:0] data0_q;
    logic [P_DATA_WIDTH-1:0] data1_q;

    // A request is only taken while that consumer has nothing outstanding
    assign acc0 = rd0.req & ~pend[0];
    assign acc1 = rd1.req & ~pend[1];

    // Grant choice: a lone pending wins outright, a tie goes to whoever was not served last
    always_comb begin
        next_grant = 1'b0;
        if (pend == 2'b11) begin
            next_grant = ~last_grant;
        end else begin
            next_grant = pend[1];
        end
    end

    // Per-consumer slot-tag latches, loaded on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr0_q <= '0;
            addr1_q <= '0;
        end else begin
            if (acc0) begin
                addr0_q <= rd0.addr;
            end
            if (acc1) begin
                addr1_q <= rd1.addr;
            end
        end
    end

    // Lookup sequencer: pending flags, grant pointer, table port and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pend        <= 2'b00;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            tbl_rd_en   <= 1'b0;
            tbl_rd_addr <= '0;
            dv0_q       <= 1'b0;
            dv1_q       <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            dv0_q     <= 1'b0;
            dv1_q     <= 1'b0;
            tbl_rd_en <= 1'b0;
            if (acc0) begin
                pend[0] <= 1'b1;
            end
            if (acc1) begin
                pend[1] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        grant       <= next_grant;
                        last_grant  <= next_grant;
                        tbl_rd_en   <= 1'b1;
                        tbl_rd_addr <= next_grant ? addr1_q : addr0_q;
                        state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= (P_RD_LATENCY == 1) ? S_DATA : S_WAIT;
                end
                S_WAIT: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    // The granted consumer's pending flag is set here, so no
                    // acceptance for it can collide with this clear
                    if (grant) begin
                        data1_q <= tbl_rd_data;
                        dv1_q   <= 1'b1;
                        pend[1] <= 1'b0;
                    end else begin
                        data0_q <= tbl_rd_data;
                        dv0_q   <= 1'b1;
                        pend[0] <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd0.rdy_n      = pend[0];
    assign rd0.data_valid = dv0_q;
    assign rd0.data       = data0_q;
    assign rd1.rdy_n      = pend[1];
    assign rd1.data_valid = dv1_q;
    assign rd1.data       = data1_q;

endmodule
